// File: rtl/serial_adder_n.sv
`default_nettype none
// =============================================================================
// Module   : serial_adder_n
// Brief    : Multi-cycle WIDTH-bit adder, DIGIT bits per clock, start/busy/done.
//            Optional macro SERADD_SUB_EN adds a 'sub' port (a - b mod 2^WIDTH).
// Revision : 1.0 - initial release
// =============================================================================
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = $clog2(NSTEP) + 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder_n: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin;
  logic             w_load;

`ifdef SERADD_SUB_EN
  // Subtraction as a + ~b + 1; c_out=1 then means no borrow.
  assign w_b_in = sub ? ~b : b;
  assign w_cin  = sub ? 1'b1 : c_in;
`else
  assign w_b_in = b;
  assign w_cin  = c_in;
`endif

  assign w_load = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_sum  = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_cy};

  generate
    if (DIGIT == WIDTH) begin : g_shift_single
      assign w_acc_next = w_sum[DIGIT-1:0];
    end else begin : g_shift_multi
      assign w_acc_next = {w_sum[DIGIT-1:0], r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == '0) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_cnt <= '0;
      s     <= '0;
      c_out <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= w_b_in;
      r_cy  <= w_cin;
      r_cnt <= CW'(NSTEP - 1);
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_cy  <= w_sum[DIGIT];
      r_acc <= w_acc_next;
      // Result registers only move on the final digit, so they hold during RUN.
      if (r_cnt == '0) begin
        s     <= w_acc_next;
        c_out <= w_sum[DIGIT];
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder; next generation of the team's 1-bit full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, reusing one DIGIT-wide ripple slice and a carry flop.
- Start/busy/done handshake; used where area matters more than latency (arithmetic datapaths, lab ALU).

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.
- DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).
- Derived NSTEP = WIDTH/DIGIT, cycles per operation; counter width = clog2(NSTEP)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- c_in  input  1  carry-in; sampled with start
- busy  output  1  high while the operation is in progress
- done  output  1  one-cycle pulse: s/c_out are updated
- s  output  WIDTH  sum, registered; holds the last result
- c_out  output  1  carry-out, registered; holds the last result

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, s=0, c_out=0; internal shift registers, carry flop and counter cleared.
- Reset mid-operation aborts it. No partial result reaches s.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge → latch a, b into shift regs; carry flop=c_in; cnt=NSTEP-1; go RUN. start=0 → stay.
- RUN: each edge, {cy, d} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - Shift d into the top of the partial-sum register; shift A and B right by DIGIT; carry flop=cy.
  - If cnt==0 → DONE, with s=final partial sum and c_out=cy. Else cnt-1.
- DONE: done=1 for exactly one cycle.
  - start=1 → latch new operands, go RUN (back-to-back, no idle cycle).
  - Else → IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE; both are registered state decodes.
- Latency: start high in cycle 0 → busy high in cycles 1..NSTEP → done high in cycle NSTEP+1.
  - Throughput is one result per NSTEP+1 cycles.
- start in RUN is ignored; operands are not re-sampled, and a/b/c_in may change freely while busy.
- s and c_out keep the previous result throughout RUN. They change only on the edge entering DONE, then hold until the next completion or reset.
- Arithmetic is unsigned modulo 2^WIDTH; c_out = bit WIDTH of a+b+c_in.
- DIGIT==WIDTH (NSTEP=1): a single RUN cycle, same handshake.

Optional Feature:
- Macro SERADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled with start. When sub=1, operand B is replaced by ~b at latch, and the effective carry-in is forced to 1 (c_in ignored). Result = a-b mod 2^WIDTH; c_out=1 means no borrow.
- Not defined: no sub port; addition only, behaviour exactly as above.

Test Plan:
- WIDTH=8, DIGIT=1: a=8'h35, b=8'h4A, c_in=0, start pulse in cycle 0 → busy in cycles 1–8, done in cycle 9, s=8'h7F, c_out=0.
- WIDTH=8, DIGIT=1: a=8'hFF, b=8'h01, c_in=1 → s=8'h01, c_out=1. Previous s value (8'h7F) holds through cycles 1–8.
- WIDTH=8, DIGIT=4: a=8'hC8, b=8'h9C, c_in=0 → done in cycle 3, s=8'h64, c_out=1. Exhaustively check all 8 full-adder truth rows using WIDTH=1, DIGIT=1.
- Back-to-back: start held high in the DONE cycle with a=8'h10, b=8'h20 → no IDLE cycle, next done exactly NSTEP+1 cycles later, s=8'h30. start pulses during RUN are ignored and the result is unchanged.
- Reset: assert rst in cycle 4 of a run → outputs 0 immediately (before the next edge), no done pulse. After release, a fresh start completes correctly.
- With SERADD_SUB_EN: a=8'h10, b=8'h20, sub=1 → s=8'hF0, c_out=0. a=8'h20, b=8'h10, sub=1 → s=8'h10, c_out=1.
